// File: rtl/fifo_tx_drain_ctrl_if.sv
// Handshake bundle between the FIFO read port, the UART TX parallel input and
// the drain controller. master = controller side, slave = FIFO/UART side.
interface fifo_tx_drain_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  ENABLE;
    logic [GAP_WIDTH-1:0]  GAP_CFG;
    logic                  FIFO_EMPTY;
    logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
    logic                  FIFO_R_INC;
    logic                  TX_BUSY;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_DATA_VALID;
    logic                  CTRL_IDLE;
    logic [CNT_WIDTH-1:0]  SENT_CNT;
    logic                  TX_ERR;

    modport master (
        input  ENABLE, GAP_CFG, FIFO_EMPTY, FIFO_RD_DATA, TX_BUSY,
        output FIFO_R_INC, TX_P_DATA, TX_DATA_VALID, CTRL_IDLE, SENT_CNT, TX_ERR
    );

    modport slave (
        output ENABLE, GAP_CFG, FIFO_EMPTY, FIFO_RD_DATA, TX_BUSY,
        input  FIFO_R_INC, TX_P_DATA, TX_DATA_VALID, CTRL_IDLE, SENT_CNT, TX_ERR
    );
endinterface

// File: rtl/fifo_tx_drain_ctrl.sv
// Read-domain sequencer: pops FIFO bytes into the UART TX with a gap and byte count.
// Optional macro TX_TIMEOUT_EN adds a TX_BUSY-rise timeout in WAIT_ACK (TX_ERR pulse).
module fifo_tx_drain_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_WIDTH      = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    fifo_tx_drain_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg,  data_next;
    logic [CNT_WIDTH-1:0]  cnt_reg,   cnt_next;
    logic [GAP_WIDTH-1:0]  gap_reg,   gap_next;

`ifdef TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_reg,   tmo_next;
    logic                  err_reg,   err_next;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            cnt_reg   <= '0;
            gap_reg   <= '0;
`ifdef TX_TIMEOUT_EN
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
`ifdef TX_TIMEOUT_EN
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
`ifdef TX_TIMEOUT_EN
        tmo_next   = tmo_reg;
        err_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // FIFO_RD_DATA is valid now; the pop strobe follows next cycle.
                if (bus.ENABLE && !bus.FIFO_EMPTY && !bus.TX_BUSY) begin
                    data_next  = bus.FIFO_RD_DATA;
                    state_next = POP;
                end
            end
            POP: state_next = SEND;
            SEND: begin
                state_next = WAIT_ACK;
`ifdef TX_TIMEOUT_EN
                tmo_next   = '0;
`endif
            end
            WAIT_ACK: begin
                if (bus.TX_BUSY) begin
                    state_next = WAIT_DONE;
                end
`ifdef TX_TIMEOUT_EN
                else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    tmo_next   = tmo_reg + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
                    cnt_next   = cnt_reg + 1'b1;
                    gap_next   = bus.GAP_CFG;
                    state_next = (bus.GAP_CFG == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_next = gap_reg - 1'b1;
                if (gap_reg <= GAP_WIDTH'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.FIFO_R_INC    = (state_reg == POP);
    assign bus.TX_DATA_VALID = (state_reg == SEND);
    assign bus.CTRL_IDLE     = (state_reg == IDLE);
    assign bus.TX_P_DATA     = data_reg;
    assign bus.SENT_CNT      = cnt_reg;
`ifdef TX_TIMEOUT_EN
    assign bus.TX_ERR        = err_reg;
`else
    assign bus.TX_ERR        = 1'b0;
`endif
endmodule

// File: doc/fifo_tx_drain_ctrl.md
Name: fifo_tx_drain_ctrl

Overview:
Read-side sequencer for the async FIFO, clocked in the FIFO read domain. Pops one byte at a time from the FIFO read port and hands it to the UART transmitter with a valid/busy handshake. Enforces a programmable inter-frame gap and counts transmitted bytes. Sits between the FIFO read interface (EMPTY/RD_DATA/R_INC) and the UART TX parallel input.

Parameters:
DATA_WIDTH, 8, width of FIFO data and TX parallel data
GAP_WIDTH, 8, width of the GAP_CFG inter-frame gap input
CNT_WIDTH, 16, width of the SENT_CNT byte counter
TIMEOUT_CYCLES, 64, cycles to wait for TX_BUSY to rise (used only with TX_TIMEOUT_EN)

Ports:
CLK  input  1  read-domain clock (same clock as the FIFO R_CLK)
RST  input  1  synchronous reset, active-high
ENABLE  input  1  permit new pops; sampled only in IDLE
GAP_CFG  input  GAP_WIDTH  idle cycles inserted after each frame; sampled on entry to GAP
FIFO_EMPTY  input  1  FIFO EMPTY flag
FIFO_RD_DATA  input  DATA_WIDTH  FIFO read data; valid while FIFO_EMPTY=0
FIFO_R_INC  output  1  one-cycle pop strobe to the FIFO
TX_BUSY  input  1  UART TX busy
TX_P_DATA  output  DATA_WIDTH  byte presented to UART TX
TX_DATA_VALID  output  1  one-cycle load strobe to UART TX
CTRL_IDLE  output  1  high only in state IDLE
SENT_CNT  output  CNT_WIDTH  bytes handed off to and accepted by TX
TX_ERR  output  1  one-cycle pulse on handshake timeout

Behaviour:
- Single clock CLK; synchronous active-high RST; all outputs registered or decoded from the state register (Moore).
- Reset values: state=IDLE, FIFO_R_INC=0, TX_DATA_VALID=0, TX_P_DATA=0, SENT_CNT=0, TX_ERR=0, CTRL_IDLE=1, gap counter=0.
- States: IDLE, POP, SEND, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: when ENABLE=1, FIFO_EMPTY=0 and TX_BUSY=0 are all true in the same cycle, capture FIFO_RD_DATA into TX_P_DATA at that edge and go to POP. Otherwise stay in IDLE.
- POP: FIFO_R_INC=1 for exactly this one cycle, then go to SEND unconditionally. FIFO_EMPTY is not sampled in POP or SEND, because the flag updates one cycle late.
- SEND: TX_DATA_VALID=1 for exactly one cycle, then go to WAIT_ACK. TX_P_DATA holds its value from capture until the next capture.
- WAIT_ACK: wait for TX_BUSY=1, then go to WAIT_DONE.
- WAIT_DONE: wait for TX_BUSY=0. On that edge, increment SENT_CNT (wraps at 2^CNT_WIDTH to 0), load the gap counter with GAP_CFG, and go to GAP. If GAP_CFG=0, go directly to IDLE instead.
- GAP: decrement the gap counter each cycle; go to IDLE on the cycle the counter reaches 1, giving exactly GAP_CFG cycles spent in GAP.
- Minimum cadence per byte: accept edge → POP(1) → SEND(1) → WAIT_ACK(≥1) → WAIT_DONE(≥1) → GAP(GAP_CFG) → IDLE(≥1).
- ENABLE deasserted mid-frame: the current frame completes; no new pop occurs until ENABLE=1 in IDLE.
- FIFO empty: the block remains in IDLE; FIFO_R_INC is never asserted while FIFO_EMPTY=1 at the accept edge.
- TX_BUSY=1 in IDLE (e.g. a foreign frame in progress): no accept until it drops.
- RST mid-operation: immediate return to reset values on the next edge. If RST lands in POP, the pop has already been issued and that byte is lost; this is accepted behaviour.

Optional Feature:
Macro TX_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK. If TX_BUSY has not risen after TIMEOUT_CYCLES cycles in WAIT_ACK, then:
  - TX_ERR pulses for one cycle,
  - SENT_CNT is not incremented,
  - the state goes to IDLE and the byte is dropped.
- Not defined: WAIT_ACK waits indefinitely, TX_ERR is tied to 0, and no counter logic is present.

Test Plan:
- Reset then idle: RST=1 for 2 cycles with FIFO_EMPTY=1 → all outputs at reset values, CTRL_IDLE=1, FIFO_R_INC never asserted.
- Single byte, GAP_CFG=0: FIFO_RD_DATA=0xA5, FIFO_EMPTY 1→0, TX model raises TX_BUSY 1 cycle after TX_DATA_VALID and holds it 10 cycles → FIFO_R_INC one pulse, TX_DATA_VALID one pulse the next cycle, TX_P_DATA=0xA5, SENT_CNT=1, back in IDLE the cycle after TX_BUSY falls.
- Burst of 3 bytes (0x11, 0x22, 0x33), GAP_CFG=4 → 3 pops and 3 valids in order, exactly 4 GAP cycles between each TX_BUSY fall and the next accept, SENT_CNT=3.
- ENABLE dropped during WAIT_DONE with FIFO non-empty → current byte completes (SENT_CNT +1), then no further FIFO_R_INC until ENABLE=1.
- RST asserted in WAIT_ACK → next cycle state IDLE, TX_DATA_VALID=0, SENT_CNT=0.
- With TX_TIMEOUT_EN, TIMEOUT_CYCLES=8 and TX_BUSY stuck at 0 → TX_ERR pulses exactly once 8 cycles into WAIT_ACK, SENT_CNT unchanged, CTRL_IDLE=1 on the next cycle.
